// File: rtl/video_timing_gen.sv
// Video timing generator: pixel-rate enable, H/V counters with zero-skew registered
// blank/sync decodes, delayed-4H tap chain and latched VB / line-compare interrupts.

module video_timing_gen_chk #(
  parameter int MCK_DIV      = 14,
  parameter int HW           = 9,
  parameter int VW           = 9,
  parameter int H_TOTAL      = 456,
  parameter int H_SYNC_END   = 400,
  parameter int V_TOTAL      = 262,
  parameter int V_SYNC_END   = 247,
  parameter int TAP_DEPTH    = 4
) ();
  if (MCK_DIV < 2) begin : g_bad_div
    $error("video_timing_gen: MCK_DIV must be at least 2");
  end
  if (H_SYNC_END > H_TOTAL) begin : g_bad_hsync
    $error("video_timing_gen: H_SYNC_END exceeds H_TOTAL");
  end
  if (H_TOTAL > (1 << HW)) begin : g_bad_hw
    $error("video_timing_gen: H_TOTAL does not fit in HW bits");
  end
  if (V_SYNC_END > V_TOTAL) begin : g_bad_vsync
    $error("video_timing_gen: V_SYNC_END exceeds V_TOTAL");
  end
  if (V_TOTAL > (1 << VW)) begin : g_bad_vw
    $error("video_timing_gen: V_TOTAL does not fit in VW bits");
  end
  if (HW < 3 || TAP_DEPTH < 1) begin : g_bad_tap
    $error("video_timing_gen: 4H tap needs HW >= 3 and TAP_DEPTH >= 1");
  end
endmodule

module video_timing_gen #(
  parameter int MCK_DIV      = 14,
  parameter int HW           = 9,
  parameter int VW           = 9,
  parameter int H_TOTAL      = 456,
  parameter int H_ACTIVE     = 336,
  parameter int H_SYNC_START = 368,
  parameter int H_SYNC_END   = 400,
  parameter int V_TOTAL      = 262,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 244,
  parameter int V_SYNC_END   = 247,
  parameter int TAP_DEPTH    = 4
) (
  input  logic                 clk100,
  input  logic                 rst_b,
  output logic                 pix_tick,
  output logic [HW-1:0]        hcount,
  output logic [VW-1:0]        vcount,
  output logic                 hblank_b,
  output logic                 vblank_b,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 vreset_b,
  output logic [TAP_DEPTH-1:0] h4_tap,
  output logic                 vbkint_b,
  input  logic                 vbkack_b,
  input  logic [VW-1:0]        line_cmp,
  input  logic                 lcint_en,
  output logic                 lcint_b,
  input  logic                 lcack_b,
  output logic [7:0]           frame_cnt
);
  localparam int DW  = $clog2(MCK_DIV);
  localparam int HW1 = HW + 1;
  localparam int VW1 = VW + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(MCK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  // Thresholds carry one extra bit so an end value equal to 2^W stays representable.
  localparam logic [HW:0]   H_ACT_C  = HW1'(H_ACTIVE);
  localparam logic [HW:0]   HSS_C    = HW1'(H_SYNC_START);
  localparam logic [HW:0]   HSE_C    = HW1'(H_SYNC_END);
  localparam logic [VW:0]   V_ACT_C  = VW1'(V_ACTIVE);
  localparam logic [VW:0]   VSS_C    = VW1'(V_SYNC_START);
  localparam logic [VW:0]   VSE_C    = VW1'(V_SYNC_END);

  video_timing_gen_chk #(
    .MCK_DIV(MCK_DIV), .HW(HW), .VW(VW), .H_TOTAL(H_TOTAL), .H_SYNC_END(H_SYNC_END),
    .V_TOTAL(V_TOTAL), .V_SYNC_END(V_SYNC_END), .TAP_DEPTH(TAP_DEPTH)
  ) u_chk ();

  logic [DW-1:0] div_r;
  logic [DW-1:0] div_nxt_s;
  logic [HW-1:0] h_nxt_s;
  logic [VW-1:0] v_nxt_s;
  logic [HW:0]   h_ext_s;
  logic [VW:0]   v_ext_s;
  logic          h_wrap_s;
  logic          v_wrap_s;
  logic          tap_shift_s;
  logic          vb_set_s;
  logic          lc_set_s;

  // Next-state values for the divider and counters, plus interrupt set conditions.
  always_comb begin
    div_nxt_s   = (div_r == DIV_LAST) ? {DW{1'b0}} : div_r + DW'(1);
    h_wrap_s    = (hcount == H_LAST);
    v_wrap_s    = (vcount == V_LAST);
    h_nxt_s     = h_wrap_s ? {HW{1'b0}} : hcount + HW'(1);
    if (h_wrap_s) begin
      v_nxt_s = v_wrap_s ? {VW{1'b0}} : vcount + VW'(1);
    end else begin
      v_nxt_s = vcount;
    end
    h_ext_s     = {1'b0, h_nxt_s};
    v_ext_s     = {1'b0, v_nxt_s};
    tap_shift_s = ~hcount[0] & h_nxt_s[0];
    vb_set_s    = pix_tick & h_wrap_s & (v_ext_s == V_ACT_C);
    // line_cmp is only looked at on the line-start tick, so mid-line changes are inert.
    lc_set_s    = pix_tick & h_wrap_s & lcint_en & (line_cmp == v_nxt_s);
  end

  // Divider, counters, decodes, tap chain and interrupt latches.
  always_ff @(posedge clk100) begin
    if (!rst_b) begin
      div_r     <= {DW{1'b0}};
      pix_tick  <= 1'b0;
      hcount    <= {HW{1'b0}};
      vcount    <= {VW{1'b0}};
      hblank_b  <= 1'b1;
      vblank_b  <= 1'b1;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      vreset_b  <= 1'b0;
      h4_tap    <= {TAP_DEPTH{1'b0}};
      vbkint_b  <= 1'b1;
      lcint_b   <= 1'b1;
      frame_cnt <= 8'd0;
    end else begin
      div_r    <= div_nxt_s;
      pix_tick <= (div_nxt_s == DIV_LAST);
      if (pix_tick) begin
        hcount   <= h_nxt_s;
        vcount   <= v_nxt_s;
        hblank_b <= (h_ext_s < H_ACT_C);
        vblank_b <= (v_ext_s < V_ACT_C);
        hsync    <= (h_ext_s >= HSS_C) && (h_ext_s < HSE_C);
        vsync    <= (v_ext_s >= VSS_C) && (v_ext_s < VSE_C);
        vreset_b <= (h_nxt_s != {HW{1'b0}}) || (v_nxt_s != {VW{1'b0}});
        if (h_wrap_s && v_wrap_s) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
        if (tap_shift_s) begin
          h4_tap[0] <= h_nxt_s[2];
          for (int k = 1; k < TAP_DEPTH; k++) begin
            h4_tap[k] <= h4_tap[k-1];
          end
        end
      end
      // A set on the same edge as an acknowledge wins so the event is never dropped.
      if (vb_set_s) begin
        vbkint_b <= 1'b0;
      end else if (!vbkack_b) begin
        vbkint_b <= 1'b1;
      end
      if (lc_set_s) begin
        lcint_b <= 1'b0;
      end else if (!lcack_b) begin
        lcint_b <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: small-geometry instance for frame/interrupt/tap behaviour and a
// default-geometry instance for one full line of decodes.

module tb_video_timing_gen;
  logic       clk100 = 1'b0;
  logic       rst_b = 1'b0, vbkack_b = 1'b1, lcint_en = 1'b0, lcack_b = 1'b1;
  logic [8:0] line_cmp = 9'd0;
  logic       pix_tick, hblank_b, vblank_b, hsync, vsync, vreset_b, vbkint_b, lcint_b;
  logic [8:0] hcount, vcount;
  logic [3:0] h4_tap;
  logic [7:0] frame_cnt;

  logic       rst_b_d = 1'b0, vbkack_b_d = 1'b1, lcint_en_d = 1'b0, lcack_b_d = 1'b1;
  logic [8:0] line_cmp_d = 9'd0;
  logic       pix_tick_d, hblank_b_d, vblank_b_d, hsync_d, vsync_d, vreset_b_d, vbkint_b_d, lcint_b_d;
  logic [8:0] hcount_d, vcount_d;
  logic [3:0] h4_tap_d;
  logic [7:0] frame_cnt_d;

  int checks = 0;
  int failures = 0;
  int px = 0;
  logic [37:0] obs, exp;
  logic [37:0] rst_exp;
  logic [3:0]  tap_m;

  always #5 clk100 = ~clk100;

  // 20 x 10 frame, 4 clocks per pixel: 200 ticks per frame.
  video_timing_gen #(
    .MCK_DIV(4), .HW(9), .VW(9), .H_TOTAL(20), .H_ACTIVE(12), .H_SYNC_START(14),
    .H_SYNC_END(17), .V_TOTAL(10), .V_ACTIVE(6), .V_SYNC_START(7), .V_SYNC_END(8),
    .TAP_DEPTH(4)
  ) dut (
    .clk100(clk100), .rst_b(rst_b), .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
    .hblank_b(hblank_b), .vblank_b(vblank_b), .hsync(hsync), .vsync(vsync),
    .vreset_b(vreset_b), .h4_tap(h4_tap), .vbkint_b(vbkint_b), .vbkack_b(vbkack_b),
    .line_cmp(line_cmp), .lcint_en(lcint_en), .lcint_b(lcint_b), .lcack_b(lcack_b),
    .frame_cnt(frame_cnt)
  );

  video_timing_gen dut_def (
    .clk100(clk100), .rst_b(rst_b_d), .pix_tick(pix_tick_d), .hcount(hcount_d),
    .vcount(vcount_d), .hblank_b(hblank_b_d), .vblank_b(vblank_b_d), .hsync(hsync_d),
    .vsync(vsync_d), .vreset_b(vreset_b_d), .h4_tap(h4_tap_d), .vbkint_b(vbkint_b_d),
    .vbkack_b(vbkack_b_d), .line_cmp(line_cmp_d), .lcint_en(lcint_en_d),
    .lcint_b(lcint_b_d), .lcack_b(lcack_b_d), .frame_cnt(frame_cnt_d)
  );

  task automatic clk_edge();
    @(posedge clk100);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    clk_edge();
    clk_edge();
    rst_b = 1'b1;
    px    = 0;
    tap_m = 4'd0;
  endtask

  task automatic step_a();
    int n = 0;
    while (pix_tick !== 1'b1 && n < 8) begin
      clk_edge();
      n++;
    end
    if (pix_tick !== 1'b1) begin
      checks++; failures++;
      $display("FAIL step_timeout got pix_tick=%b want 1 within 8 clocks", pix_tick);
    end
    clk_edge();
    px++;
  endtask

  task automatic step_d();
    int n = 0;
    while (pix_tick_d !== 1'b1 && n < 20) begin
      clk_edge();
      n++;
    end
    if (pix_tick_d !== 1'b1) begin
      checks++; failures++;
      $display("FAIL step_def_timeout got pix_tick=%b want 1 within 20 clocks", pix_tick_d);
    end
    clk_edge();
  endtask

  task automatic test_reset();
    logic e;
    do_reset();
    obs = {pix_tick, hcount, vcount, hblank_b, vblank_b, hsync, vsync, vreset_b, h4_tap,
           vbkint_b, lcint_b, frame_cnt};
    checks++;
    if (obs !== rst_exp) begin
      failures++; $display("FAIL reset_values got=%h want=%h", obs, rst_exp);
    end
    for (int k = 1; k <= 8; k++) begin
      clk_edge();
      e = (k == 3) || (k == 7);
      checks++;
      if (pix_tick !== e) begin
        failures++; $display("FAIL tick_cadence clk=%0d got=%b want=%b", k, pix_tick, e);
      end
      if (k == 4) begin
        checks++;
        if (hcount !== 9'd1 || vreset_b !== 1'b1) begin
          failures++; $display("FAIL first_tick got h=%0d vreset_b=%b want h=1 vreset_b=1", hcount, vreset_b);
        end
      end
    end
  endtask

  task automatic test_frame();
    int h, v, f, vr_low, hs_line0;
    logic [30:0] o, x;
    do_reset();
    vr_low = 0; hs_line0 = 0;
    for (int n = 1; n <= 200; n++) begin
      step_a();
      h = px % 20; v = (px / 20) % 10; f = px / 200;
      o = {hcount, vcount, hblank_b, vblank_b, hsync, vsync, vreset_b, frame_cnt};
      x = {9'(h), 9'(v), (h < 12), (v < 6), (h >= 14 && h < 17), (v == 7),
           !(h == 0 && v == 0), 8'(f)};
      checks++;
      if (o !== x) begin
        failures++; $display("FAIL frame_decode px=%0d got=%h want=%h", px, o, x);
      end
      if (vreset_b === 1'b0) vr_low++;
      if (vcount === 9'd0 && hsync === 1'b1) hs_line0++;
    end
    checks++;
    if (vr_low != 1) begin
      failures++; $display("FAIL vreset_width got=%0d ticks want=1", vr_low);
    end
    checks++;
    if (hs_line0 != 3) begin
      failures++; $display("FAIL hsync_width got=%0d ticks want=3", hs_line0);
    end
  endtask

  task automatic test_taps();
    int hp, h;
    logic [8:0] hb;
    do_reset();
    for (int n = 1; n <= 64; n++) begin
      hp = px % 20;
      step_a();
      h = px % 20; hb = 9'(h);
      if (hp % 2 == 0 && h % 2 == 1) tap_m = {tap_m[2:0], hb[2]};
      checks++;
      if (h4_tap !== tap_m) begin
        failures++; $display("FAIL tap_chain px=%0d got=%b want=%b", px, h4_tap, tap_m);
      end
      if (px == 7) begin
        checks++;
        if (h4_tap !== 4'b0011) begin
          failures++; $display("FAIL tap_hand px=7 got=%b want=0011", h4_tap);
        end
      end
    end
  endtask

  task automatic test_vbint();
    int highs = 0;
    vbkack_b = 1'b1;
    do_reset();
    while (px < 119) step_a();
    checks++;
    if (vbkint_b !== 1'b1) begin failures++; $display("FAIL vb_before got=%b want=1", vbkint_b); end
    step_a();
    checks++;
    if (vbkint_b !== 1'b0) begin failures++; $display("FAIL vb_set got=%b want=0", vbkint_b); end
    while (px < 420) begin
      step_a();
      if (vbkint_b !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin failures++; $display("FAIL vb_hold got=%0d high ticks want=0", highs); end
    vbkack_b = 1'b0;
    clk_edge();
    vbkack_b = 1'b1;
    checks++;
    if (vbkint_b !== 1'b1) begin failures++; $display("FAIL vb_ack got=%b want=1", vbkint_b); end
    while (px < 519) step_a();
    for (int n = 0; n < 8 && pix_tick !== 1'b1; n++) clk_edge();
    vbkack_b = 1'b0;
    clk_edge();
    vbkack_b = 1'b1;
    px++;
    clk_edge();
    clk_edge();
    checks++;
    if (vbkint_b !== 1'b0 || vcount !== 9'd6 || hcount !== 9'd0) begin
      failures++; $display("FAIL vb_set_wins got vbkint_b=%b pos=(%0d,%0d) want 0 at (0,6)", vbkint_b, hcount, vcount);
    end
  endtask

  task automatic test_linecmp();
    int lows;
    lcint_en = 1'b1; line_cmp = 9'd3;
    do_reset();
    while (px < 59) step_a();
    checks++;
    if (lcint_b !== 1'b1) begin failures++; $display("FAIL lc_before got=%b want=1", lcint_b); end
    step_a();
    checks++;
    if (lcint_b !== 1'b0) begin failures++; $display("FAIL lc_fire_line3 got=%b want=0", lcint_b); end
    step_a();
    lcack_b = 1'b0;
    clk_edge();
    lcack_b = 1'b1;
    checks++;
    if (lcint_b !== 1'b1) begin failures++; $display("FAIL lc_ack got=%b want=1", lcint_b); end
    while (px < 65) step_a();
    line_cmp = 9'd3;
    while (px < 85) step_a();
    checks++;
    if (lcint_b !== 1'b1) begin failures++; $display("FAIL lc_midline got=%b want=1", lcint_b); end
    line_cmp = 9'd5;
    while (px < 99) step_a();
    checks++;
    if (lcint_b !== 1'b1) begin failures++; $display("FAIL lc_early got=%b want=1", lcint_b); end
    step_a();
    checks++;
    if (lcint_b !== 1'b0) begin failures++; $display("FAIL lc_fire_line5 got=%b want=0", lcint_b); end
    lcack_b = 1'b0;
    clk_edge();
    lcack_b = 1'b1;
    line_cmp = 9'd12;
    lows = 0;
    while (px < 320) begin step_a(); if (lcint_b !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin failures++; $display("FAIL lc_out_of_range got=%0d low ticks want=0", lows); end
    line_cmp = 9'd3; lcint_en = 1'b0;
    lows = 0;
    while (px < 520) begin step_a(); if (lcint_b !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin failures++; $display("FAIL lc_disabled got=%0d low ticks want=0", lows); end
  endtask

  task automatic test_reset_mid();
    lcint_en = 1'b1; line_cmp = 9'd6;
    do_reset();
    while (px < 128) step_a();
    checks++;
    if (vbkint_b !== 1'b0 || lcint_b !== 1'b0 || hcount !== 9'd8 || vcount !== 9'd6) begin
      failures++; $display("FAIL mid_setup got vb=%b lc=%b pos=(%0d,%0d) want 0 0 (8,6)", vbkint_b, lcint_b, hcount, vcount);
    end
    clk_edge();
    clk_edge();
    rst_b = 1'b0;
    clk_edge();
    rst_b = 1'b1;
    lcint_en = 1'b0;
    obs = {pix_tick, hcount, vcount, hblank_b, vblank_b, hsync, vsync, vreset_b, h4_tap,
           vbkint_b, lcint_b, frame_cnt};
    checks++;
    if (obs !== rst_exp) begin failures++; $display("FAIL mid_reset got=%h want=%h", obs, rst_exp); end
    clk_edge(); clk_edge(); clk_edge();
    checks++;
    if (pix_tick !== 1'b1 || hcount !== 9'd0) begin
      failures++; $display("FAIL restart_tick got pix=%b h=%0d want 1 0", pix_tick, hcount);
    end
    clk_edge();
    checks++;
    if (hcount !== 9'd1 || vcount !== 9'd0 || vbkint_b !== 1'b1 || lcint_b !== 1'b1) begin
      failures++; $display("FAIL restart_count got h=%0d v=%0d vb=%b lc=%b want 1 0 1 1", hcount, vcount, vbkint_b, lcint_b);
    end
  endtask

  task automatic test_defaults();
    int fall_h = -1, hs_first = -1, hs_last = -1, hs_cnt = 0;
    rst_b_d = 1'b0;
    clk_edge();
    clk_edge();
    rst_b_d = 1'b1;
    checks++;
    if (hcount_d !== 9'd0 || hblank_b_d !== 1'b1 || vreset_b_d !== 1'b0 || pix_tick_d !== 1'b0) begin
      failures++; $display("FAIL def_reset got h=%0d hb=%b vr=%b pix=%b want 0 1 0 0", hcount_d, hblank_b_d, vreset_b_d, pix_tick_d);
    end
    for (int n = 1; n < 456; n++) begin
      step_d();
      if (hblank_b_d === 1'b0 && fall_h < 0) fall_h = int'(hcount_d);
      if (hsync_d === 1'b1) begin
        if (hs_first < 0) hs_first = int'(hcount_d);
        hs_last = int'(hcount_d);
        hs_cnt++;
      end
    end
    checks++;
    if (fall_h != 336) begin failures++; $display("FAIL def_hblank_fall got=%0d want=336", fall_h); end
    checks++;
    if (hs_first != 368 || hs_last != 399 || hs_cnt != 32) begin
      failures++; $display("FAIL def_hsync got=%0d..%0d n=%0d want=368..399 n=32", hs_first, hs_last, hs_cnt);
    end
    step_d();
    checks++;
    if (hcount_d !== 9'd0 || vcount_d !== 9'd1 || hblank_b_d !== 1'b1 || vblank_b_d !== 1'b1) begin
      failures++; $display("FAIL def_line_wrap got h=%0d v=%0d hb=%b vb=%b want 0 1 1 1", hcount_d, vcount_d, hblank_b_d, vblank_b_d);
    end
  endtask

  initial begin
    rst_exp = {1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'd0};
    test_reset();
    test_frame();
    test_taps();
    test_vbint();
    test_linecmp();
    test_reset_mid();
    test_defaults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed-geometry system clock/sync generator in the graphics subsystem.
- From the 100 MHz board clock it produces:
  - a pixel-rate enable;
  - H/V counters;
  - blank and sync strobes;
  - a delayed-4H tap chain (the 2HDL/4HDL/4HDD/4HD3 family, no longer hand-built outside the block);
  - vertical-blank and line-compare interrupts with acknowledge handshakes.
- Geometry, divide ratio and tap depth are parameters.
- The runtime line-compare interrupt is new behaviour.

Parameters:
- MCK_DIV, 14: clk100 cycles per pixel tick (≥2).
- HW, 9: horizontal counter width.
- VW, 9: vertical counter width.
- H_TOTAL, 456: pixels per line.
- H_ACTIVE, 336: visible pixels; hcount 0..H_ACTIVE-1.
- H_SYNC_START, 368: first hcount with hsync high.
- H_SYNC_END, 400: first hcount with hsync low again.
- V_TOTAL, 262: lines per frame.
- V_ACTIVE, 240: visible lines.
- V_SYNC_START, 244: first line with vsync high.
- V_SYNC_END, 247: first line with vsync low again.
- TAP_DEPTH, 4: number of delayed 4H taps.

Ports:
- clk100  in  1  board clock; all logic on its rising edge.
- rst_b  in  1  synchronous active-low reset.
- pix_tick  out  1  one-clk100 pulse per pixel (MCKR-equivalent enable).
- hcount  out  HW  horizontal position.
- vcount  out  VW  vertical position.
- hblank_b  out  1  low outside active pixels.
- vblank_b  out  1  low outside active lines.
- hsync  out  1  active-high horizontal sync.
- vsync  out  1  active-high vertical sync.
- vreset_b  out  1  low for the single pixel tick at hcount=0, vcount=0.
- h4_tap  out  TAP_DEPTH  tap[k] = hcount[2] delayed (k+1) 1H-rise events.
- vbkint_b  out  1  vertical-blank interrupt, active low, latched.
- vbkack_b  in  1  VB interrupt acknowledge, active low.
- line_cmp  in  VW  line-compare value, sampled at each line start.
- lcint_en  in  1  line-compare interrupt enable.
- lcint_b  out  1  line-compare interrupt, active low, latched.
- lcack_b  in  1  line-compare acknowledge, active low.
- frame_cnt  out  8  frames completed, wraps 255→0.

Behaviour:
- Reset (rst_b low at an edge), all registered next cycle:
  - divider=0, pix_tick=0, hcount=0, vcount=0;
  - hblank_b=1, vblank_b=1, hsync=0, vsync=0, vreset_b=0;
  - h4_tap=0, vbkint_b=1, lcint_b=1, frame_cnt=0.
  - Reset mid-line aborts immediately; no partial interrupt survives.
- Divider:
  - counts 0..MCK_DIV-1 and wraps;
  - pix_tick is high during the clk100 cycle in which the divider equals MCK_DIV-1;
  - first tick after reset release is MCK_DIV cycles later.
- Counters advance only on pix_tick:
  - hcount wraps H_TOTAL-1→0;
  - on that wrap, vcount increments;
  - vcount wraps V_TOTAL-1→0;
  - frame_cnt increments when both wrap together.
- Decodes are registered and computed from the next counter values, so they align exactly with hcount/vcount (zero skew):
  - hblank_b = hcount<H_ACTIVE;
  - vblank_b = vcount<V_ACTIVE;
  - hsync = H_SYNC_START≤hcount<H_SYNC_END;
  - vsync likewise;
  - vreset_b = !(hcount==0 && vcount==0).
- Tap chain:
  - shifts on pix_tick when hcount[0] goes 0→1 (1H rise);
  - tap[0] ← hcount[2], tap[k] ← tap[k-1];
  - hold otherwise.
- VB interrupt:
  - set low on the tick where the counters become (0, V_ACTIVE);
  - cleared to 1 on the first clk100 edge with vbkack_b=0;
  - held low otherwise;
  - set and ack on the same edge: set wins, so the interrupt is not lost.
- Line compare:
  - line_cmp is captured on the tick where hcount becomes 0;
  - if lcint_en=1 and captured value equals the new vcount, lcint_b goes low on that same tick;
  - cleared by lcack_b=0, with the same set-wins rule;
  - line_cmp ≥ V_TOTAL never fires;
  - changing line_cmp mid-line has no effect until the next line start.
- Outputs change only at pix_tick or reset, except the interrupt clears, which act on any clk100 edge.
- Elaboration asserts:
  - H_SYNC_END ≤ H_TOTAL;
  - H_TOTAL ≤ 2^HW;
  - the same two checks vertically.

Test Plan:
- Reset then release, MCK_DIV=4 → first pix_tick at cycle 4, then every 4 cycles; hcount=1 after first tick; all outputs at reset values before it.
- Default params, run one frame → hblank_b falls at hcount 336; hsync high for hcount 368..399; vblank_b low for lines 240..261; frame_cnt 0→1 at wrap (456×262 ticks); vreset_b low for exactly one tick.
- Hold vbkack_b=1 through two frames → vbkint_b low from line 240 and stays low; pulse vbkack_b=0 → high next edge; ack asserted on the set tick → vbkint_b stays low.
- lcint_en=1, line_cmp=100 → lcint_b low at (0,100) only; line_cmp=300 → never; lcint_en=0 → never.
- TAP_DEPTH=4, track h4_tap against a software model of hcount[2] over 64 pixels → exact match, tap[3] lags tap[0] by three 1H rises.
- Assert rst_b at hcount 200, line 241, with vbkint_b low → all outputs at reset values after one clk100 edge; clean restart.
